// File: rtl/uart_baud_pkg.sv
// Shared constants and types for the UART baud-rate tick generator.
// Contents: default divisor/oversample sizing, the divisor type and a
// helper that sizes the oversample counter.
package uart_baud_pkg;

  localparam int unsigned OVERSAMPLE_DEFAULT = 16;
  localparam int unsigned DIV_WIDTH_DEFAULT  = 16;

  typedef logic [DIV_WIDTH_DEFAULT-1:0] baud_div_t;

  // Width of a counter spanning 0..os-1 (never less than one bit).
  function automatic int unsigned os_cnt_width(input int unsigned os);
    return (os > 1) ? $clog2(os) : 1;
  endfunction

  localparam int unsigned OS_CNT_W_DEFAULT = os_cnt_width(OVERSAMPLE_DEFAULT);

endpackage

// File: rtl/uart_baud_gen_wrap_counter.sv
// Generic wrapping up-counter: counts 0..max_i and returns to 0.
// Ports:
//   clk_i, arst_ni : clock, synchronous active-low reset
//   clr_i          : synchronous clear (wins over inc_i)
//   inc_i          : advance request
//   max_i          : terminal count
//   cnt_o          : current count
//   wrap_o         : combinational, high when this advance wraps to 0
module wrap_counter
  import uart_baud_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             arst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] max_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q;

  // Compare before incrementing so the count never overflows.
  assign wrap_o = inc_i & (cnt_q == max_i);
  assign cnt_o  = cnt_q;

  // Count register.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= wrap_o ? '0 : cnt_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud-rate tick generator for the APB UART.
// Produces registered one-cycle oversample, mid-bit and bit-boundary strobes
// from a programmable clock divisor. New divisors are taken only while idle,
// stalled, or on the edge that completes a bit, so a rate change never
// splits a bit.
// Ports:
//   clk_i, arst_ni : clock, synchronous active-low reset
//   en_i           : generator enable (low clears both counters)
//   div_i          : requested divisor N (clocks per oversample tick)
//   div_valid_i    : divisor update request
//   div_ready_o    : combinational, update accepted this cycle if valid
//   os_tick_o      : oversample strobe
//   mid_tick_o     : mid-bit strobe (RX sample point)
//   bit_tick_o     : bit-boundary strobe
//   div_o          : active divisor
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEFAULT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 en_i,
  input  logic [DIV_WIDTH-1:0] div_i,
  input  logic                 div_valid_i,
  output logic                 div_ready_o,
  output logic                 os_tick_o,
  output logic                 mid_tick_o,
  output logic                 bit_tick_o,
  output logic [DIV_WIDTH-1:0] div_o
);

  localparam int unsigned OS_W = os_cnt_width(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_max;
  logic [DIV_WIDTH-1:0] unused_cyc_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic                 div_zero;
  logic                 run;
  logic                 load;
  logic                 cnt_clr;
  logic                 cyc_wrap;
  logic                 os_wrap;
  logic                 mid_c;
  logic                 os_tick_q;
  logic                 mid_tick_q;
  logic                 bit_tick_q;

  assign div_zero = (div_q == '0);
  assign run      = en_i & ~div_zero;
  assign div_max  = div_q - DIV_WIDTH'(1);

  // Disable, stall and divisor load all restart the phase from zero.
  assign cnt_clr = ~run | load;

  // Clock-per-oversample-tick counter; wrap_o is the oversample tick.
  wrap_counter #(
    .WIDTH (DIV_WIDTH)
  ) u_cyc_cnt (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .clr_i   (cnt_clr),
    .inc_i   (run),
    .max_i   (div_max),
    .cnt_o   (unused_cyc_cnt),
    .wrap_o  (cyc_wrap)
  );

  // Oversample-ticks-per-bit counter; wrap_o marks the bit boundary.
  wrap_counter #(
    .WIDTH (OS_W)
  ) u_os_cnt (
    .clk_i   (clk_i),
    .arst_ni (arst_ni),
    .clr_i   (cnt_clr),
    .inc_i   (cyc_wrap),
    .max_i   (OS_LAST),
    .cnt_o   (os_cnt),
    .wrap_o  (os_wrap)
  );

  assign mid_c = cyc_wrap & (os_cnt == OS_MID);

  // os_wrap is already qualified by run, so it is the bit-completion edge.
  assign div_ready_o = ~en_i | div_zero | os_wrap;
  assign load        = div_valid_i & div_ready_o;

  // Divisor and strobe registers; a load on the bit edge keeps that strobe.
  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      div_q      <= '0;
      os_tick_q  <= 1'b0;
      mid_tick_q <= 1'b0;
      bit_tick_q <= 1'b0;
    end else begin
      if (load) begin
        div_q <= div_i;
      end
      os_tick_q  <= cyc_wrap;
      mid_tick_q <= mid_c;
      bit_tick_q <= os_wrap;
    end
  end

  assign os_tick_o  = os_tick_q;
  assign mid_tick_o = mid_tick_q;
  assign bit_tick_o = bit_tick_q;
  assign div_o      = div_q;

endmodule

// File: doc/uart_baud_gen.md
Name: uart_baud_gen

Overview:
- Baud-rate tick generator for the APB UART.
- Consumes the system clock and reset (clk_i / arst_ni) produced by the control layer.
- Produces single-cycle oversample, mid-bit and bit-boundary strobes for the TX and RX engines.
- Divisor is loaded through a valid/ready handshake so that rate changes never split a bit.

Parameters:
- DIV_WIDTH, 16, width of the clock-per-oversample-tick divisor.
- OVERSAMPLE, 16, oversample ticks per UART bit; must be an even number ≥ 4.

Ports:
- clk_i  input  1  system clock; all logic rising-edge.
- arst_ni  input  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low).
- en_i  input  1  generator enable.
- div_i  input  DIV_WIDTH  new divisor N (clk_i cycles per oversample tick).
- div_valid_i  input  1  divisor update request.
- div_ready_o  output  1  divisor update may be accepted this cycle.
- os_tick_o  output  1  oversample strobe, one cycle wide.
- mid_tick_o  output  1  mid-bit strobe (RX sample point).
- bit_tick_o  output  1  bit-boundary strobe.
- div_o  output  DIV_WIDTH  currently active divisor.

Behaviour:
- Reset (arst_ni low at a rising edge):
  - div_q=0, cycle counter=0, oversample counter=0.
  - All tick outputs 0; div_o=0; div_ready_o=1.
  - Reset overrides every other input, including mid-operation.
- Divisor semantics:
  - N=0: generator stalls; no ticks even with en_i=1.
  - N=1: os_tick_o every cycle.
  - Otherwise one os tick every N cycles.
- Cycle counter:
  - Counts 0..N-1 while en_i=1 and N≠0.
  - Wraps to 0 on reaching N-1; that same edge registers os_tick_o=1 for the following cycle.
  - First os_tick_o pulse appears N cycles after the first edge at which en_i is sampled high; subsequent pulses are every N cycles.
- Oversample counter:
  - Advances on each os tick, range 0..OVERSAMPLE-1, wraps to 0.
  - mid_tick_o is coincident with the os tick that moves the counter from OVERSAMPLE/2-1 to OVERSAMPLE/2.
  - bit_tick_o is coincident with the os tick that wraps the counter to 0.
  - All strobes are registered, exactly one cycle wide, and aligned with os_tick_o.
- en_i low:
  - Both counters are cleared synchronously at the next edge.
  - Tick outputs are 0 from that edge onward.
  - Re-enable restarts from count 0, giving a deterministic phase.
- div_ready_o (combinational):
  - = ~en_i | N==0 | (bit-wrap condition this cycle, i.e. the edge that will raise bit_tick_o).
- Update accepted on an edge with div_valid_i & div_ready_o:
  - div_q <= div_i.
  - Both counters <= 0.
  - div_o updates at the same edge.
- Simultaneous update and bit wrap: the bit_tick_o for the completing bit is still issued; the new rate applies from the next cycle.
- div_valid_i with ready low: no effect; the requester holds div_valid_i and div_i stable.
- Counter arithmetic is unsigned DIV_WIDTH and $clog2(OVERSAMPLE). No overflow is possible because the compare is against N-1 before increment.

Decomposition:
- Package uart_baud_pkg:
  - OVERSAMPLE_DEFAULT = 16, DIV_WIDTH_DEFAULT = 16.
  - typedef baud_div_t (logic [DIV_WIDTH_DEFAULT-1:0]).
  - Localparam helper for the oversample counter width.
- Sub-module wrap_counter (params WIDTH; ports clk_i, arst_ni, clr_i, inc_i, max_i, cnt_o, wrap_o):
  - Instantiated once for the cycle counter and once for the oversample counter.

Test Plan:
- Reset, then en_i=1 with div_q=0 → no ticks for 100 cycles; div_ready_o=1; div_o=0.
- Load N=4 while idle, OVERSAMPLE=16, en_i=1 → os_tick_o at cycles 4, 8, 12…; mid_tick_o on the 8th os tick (cycle 32); bit_tick_o on the 16th (cycle 64), repeating every 64 cycles.
- N=1 → os_tick_o high every cycle; bit_tick_o every 16 cycles, cycles 16, 32, 48…
- While running with N=4, assert div_valid_i with div_i=2 at cycle 10 → held off until the bit-wrap edge at cycle 63; div_o=2 after it; bit_tick_o still at cycle 64; next bit_tick_o at 64+32=96.
- Drop en_i mid-bit (cycle 20), re-raise at cycle 30 → no ticks during 21..30; first os_tick_o 4 cycles after re-enable.
- Assert arst_ni=0 for one cycle mid-bit → all outputs 0 next cycle; div_o=0; no further ticks until a new divisor is loaded.
